// File: rtl/serial_frame_receiver.sv
// Serial-to-parallel frame receiver with valid/ready output holding stage.
// Ports: clk, reset_n, ser_in/ser_valid/frame_start/msb_first in; data_out/data_valid/busy/overrun out.
module serial_frame_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             msb_first,
  input  logic             data_ready,
  input  logic             overrun_clr,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q;
  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_nxt;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_nxt;
  logic             order_q;
  logic             order_nxt;
  logic             shift_en;
  logic             done;
  logic             take;
  logic             ovr_set;

  // frame_start restarts a frame from any state, so
  // it also selects the order used for this bit.
  always_comb begin
    shift_en  = ser_valid &
                (frame_start | (state_q == SHIFT));
    order_nxt = frame_start ? msb_first : order_q;
    cnt_nxt   = frame_start ? CW'(1)
                            : cnt_q + CW'(1);
    sr_nxt    = order_nxt
              ? {sr_q[WIDTH-2:0], ser_in}
              : {ser_in, sr_q[WIDTH-1:1]};
    done      = shift_en & (cnt_nxt == CW'(WIDTH));
    take      = data_valid & data_ready;
    ovr_set   = done & data_valid & ~data_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      order_q <= 1'b0;
    end else if (shift_en) begin
      sr_q    <= sr_nxt;
      order_q <= order_nxt;
      unique case (1'b1)
        done: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= cnt_nxt;
          state_q <= SHIFT;
        end
      endcase
    end
  end

  assign busy = (state_q == SHIFT);

  // A completed word may replace the held one only
  // when that one leaves on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      unique case (1'b1)
        done & ~ovr_set: begin
          data_out   <= sr_nxt;
          data_valid <= 1'b1;
        end
        take & ~done: begin
          data_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Set wins over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Self-checking bench for serial_frame_receiver.
// Directed spec scenarios plus random traffic against a frame-level model.
module tb_serial_frame_receiver;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic         ser_in;
  logic         ser_valid;
  logic         frame_start;
  logic         msb_first;
  logic         data_ready;
  logic         overrun_clr;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;

  int n_cmp;
  int n_bad;

  // frame-level reference state
  bit         m_active;
  bit         m_bits [W];
  int         m_n;
  bit         m_order;
  bit [W-1:0] m_out;
  bit         m_valid;
  bit         m_ovr;

  serial_frame_receiver #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ser_in      (ser_in),
    .ser_valid   (ser_valid),
    .frame_start (frame_start),
    .msb_first   (msb_first),
    .data_ready  (data_ready),
    .overrun_clr (overrun_clr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_n      = 0;
    m_order  = 0;
    m_out    = '0;
    m_valid  = 0;
    m_ovr    = 0;
  endtask

  // Advance model by one clock edge using the driven inputs.
  task automatic model_edge(input bit sv, input bit fs,
                            input bit b, input bit msb,
                            input bit rdy, input bit clr);
    bit         completed;
    bit [W-1:0] word;
    bit         set;
    completed = 0;
    word      = '0;
    set       = 0;
    if (sv && fs) begin
      m_active = 1;
      m_n      = 0;
      m_order  = msb;
    end
    if (sv && m_active) begin
      m_bits[m_n] = b;
      m_n++;
      if (m_n == W) begin
        for (int i = 0; i < W; i++) begin
          if (m_order) word[W-1-i] = m_bits[i];
          else         word[i]     = m_bits[i];
        end
        completed = 1;
        m_active  = 0;
        m_n       = 0;
      end
    end
    if (completed) begin
      if (!m_valid || rdy) begin
        m_out   = word;
        m_valid = 1;
      end else begin
        set = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (set)      m_ovr = 1;
    else if (clr) m_ovr = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"}, 32'(data_out), 32'(m_out));
    chk({tag, ".valid"}, 32'(data_valid), 32'(m_valid));
    chk({tag, ".busy"}, 32'(busy), 32'(m_active));
    chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic step(input bit sv, input bit fs,
                      input bit b, input bit msb,
                      input bit rdy, input bit clr,
                      input string tag);
    ser_valid   = sv;
    frame_start = fs;
    ser_in      = b;
    msb_first   = msb;
    data_ready  = rdy;
    overrun_clr = clr;
    @(posedge clk);
    model_edge(sv, fs, b, msb, rdy, clr);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input bit rdy, input bit clr,
                      input string tag);
    step(0, 0, 0, 0, rdy, clr, tag);
  endtask

  // Send WIDTH bits of word; optional one-cycle gaps.
  task automatic send(input bit [W-1:0] word,
                      input bit msb, input bit rdy,
                      input bit rdy_last, input bit gap,
                      input string tag);
    bit b;
    for (int i = 0; i < W; i++) begin
      b = msb ? word[W-1-i] : word[i];
      step(1, i == 0, b, msb,
           (i == W-1) ? rdy_last : rdy, 0, tag);
      if (gap && i != W-1) idle(rdy, 0, tag);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    reset_n     = 1'b0;
    ser_in      = 1'b0;
    ser_valid   = 1'b0;
    frame_start = 1'b0;
    msb_first   = 1'b0;
    data_ready  = 1'b0;
    overrun_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    reset_n = 1'b1;
    idle(1, 0, "post_reset");

    // MSB-first A5
    send(8'hA5, 1, 1, 1, 0, "a5_msb");
    chk("a5_msb.lit", 32'(data_out), 32'hA5);
    chk("a5_msb.v", 32'(data_valid), 32'd1);
    idle(1, 0, "drain1");

    // LSB-first palindrome and 03
    send(8'hA5, 0, 1, 1, 0, "a5_lsb");
    chk("a5_lsb.lit", 32'(data_out), 32'hA5);
    send(8'h03, 0, 1, 1, 0, "x03_lsb");
    chk("x03_lsb.lit", 32'(data_out), 32'h03);
    idle(1, 0, "drain2");

    // ser_valid gaps
    send(8'h3C, 1, 1, 1, 1, "gap3c");
    chk("gap3c.lit", 32'(data_out), 32'h3C);
    idle(1, 0, "drain3");

    // overrun with back-to-back frames
    send(8'h11, 1, 0, 0, 0, "ovr11");
    send(8'h22, 1, 0, 0, 0, "ovr22");
    chk("ovr.keep", 32'(data_out), 32'h11);
    chk("ovr.flag", 32'(overrun), 32'd1);
    idle(0, 1, "ovr_clr");
    chk("ovr.clr", 32'(overrun), 32'd0);
    idle(1, 0, "ovr_take");
    chk("ovr.take", 32'(data_valid), 32'd0);

    // completion coincides with transfer
    send(8'h33, 1, 0, 0, 0, "sim33");
    send(8'h44, 1, 0, 1, 0, "sim44");
    chk("sim.v", 32'(data_valid), 32'd1);
    chk("sim.out", 32'(data_out), 32'h44);
    chk("sim.ovr", 32'(overrun), 32'd0);
    idle(1, 0, "drain4");

    // set beats clear in the same cycle
    send(8'h55, 1, 0, 0, 0, "sc55");
    for (int i = 0; i < W; i++)
      step(1, i == 0, 1'b0, 1, 0, i == W-1, "sc00");
    chk("sc.set_wins", 32'(overrun), 32'd1);
    idle(1, 1, "sc_clr");

    // abort: 5 bits of FF then full 5A
    for (int i = 0; i < 5; i++)
      step(1, i == 0, 1'b1, 1, 1, 0, "abort_ff");
    send(8'h5A, 1, 1, 1, 0, "abort5a");
    chk("abort.lit", 32'(data_out), 32'h5A);
    idle(1, 0, "drain5");

    // stray bits while idle are ignored
    step(1, 0, 1, 1, 1, 0, "stray");
    chk("stray.busy", 32'(busy), 32'd0);

    // reset mid-frame with a word held
    send(8'h7E, 1, 0, 0, 0, "pre_rst");
    for (int i = 0; i < 4; i++)
      step(1, i == 0, 1'b1, 1, 0, 0, "mid_rst");
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(1, 0, 1'b1, 1, 1, 0, "after_rst");
    chk("after_rst.v", 32'(data_valid), 32'd0);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(3, 0) != 0,
           $urandom_range(9, 0) == 0,
           1'($urandom), 1'($urandom),
           1'($urandom),
           $urandom_range(7, 0) == 0,
           "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
